// File: rtl/maze_pkg.sv
// ============================================================================
// Module      : maze_pkg
// Description : Shared maze definitions: game states, move states, size limits
//               and the wall-map index function used by controller and renderer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

    typedef enum logic [1:0] {
        ST_WELCOME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_WIN     = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_CALC  = 2'd1,
        M_CHECK = 2'd2,
        M_WAIT  = 2'd3
    } move_state_t;

    localparam logic [4:0] START_POS = 5'd1;
    localparam logic [4:0] NUM_MIN   = 5'd5;
    localparam logic [4:0] NUM_MAX   = 5'd19;

    // Row-major wall-map bit index; for legal sizes the result never exceeds 360.
    function automatic logic [8:0] map_index(input logic [4:0] x,
                                             input logic [4:0] y,
                                             input logic [4:0] n);
        logic [9:0] w_prod;
        w_prod = ({5'd0, y} * {5'd0, n}) + {5'd0, x};
        return w_prod[8:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/maze_game_ctrl_key_cond.sv
// ============================================================================
// Module      : key_cond
// Description : Button conditioning: 2-flop synchronizer, debounce, press pulse
//               and optional auto-repeat while the key stays held.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module key_cond #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_pulse
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [DBW-1:0] c_DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPW-1:0] c_REP_LAST = RPW'(REPEAT_CYCLES - 1);

    logic [1:0]     r_sync;
    logic           r_level;
    logic [DBW-1:0] r_db_cnt;
    logic [RPW-1:0] r_rep_cnt;
    logic           r_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_level   <= 1'b0;
            r_db_cnt  <= '0;
            r_rep_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key};
            r_pulse <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_level   <= r_sync[1];
                    r_db_cnt  <= '0;
                    r_rep_cnt <= '0;
                    r_pulse   <= r_sync[1];
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
                // Repeat period restarts at every debounced rise.
                if (REPEAT_EN && r_level) begin
                    if (r_rep_cnt == c_REP_LAST) begin
                        r_rep_cnt <= '0;
                        r_pulse   <= 1'b1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt + RPW'(1);
                    end
                end
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/maze_game_ctrl.sv
// ============================================================================
// Module      : maze_game_ctrl
// Description : Welcome/play/win sequencer owning the player position; moves are
//               validated against the wall map and committed on frame_start.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic         vga_clk,
    input  logic         rst_sys,
    input  logic         key_up,
    input  logic         key_down,
    input  logic         key_left,
    input  logic         key_right,
    input  logic         key_start,
    input  logic         frame_start,
    input  logic [4:0]   num,
    input  logic [360:0] map,
    output logic [1:0]   state,
    output logic [4:0]   x_index,
    output logic [4:0]   y_index,
    output logic [9:0]   step_count,
    output logic         move_busy
);

    logic w_p_up, w_p_down, w_p_left, w_p_right, w_p_start;

    key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_key_up    (.clk(vga_clk), .rst(rst_sys), .i_key(key_up),    .o_pulse(w_p_up));
    key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_key_down  (.clk(vga_clk), .rst(rst_sys), .i_key(key_down),  .o_pulse(w_p_down));
    key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_key_left  (.clk(vga_clk), .rst(rst_sys), .i_key(key_left),  .o_pulse(w_p_left));
    key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1))
        u_key_right (.clk(vga_clk), .rst(rst_sys), .i_key(key_right), .o_pulse(w_p_right));
    key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0))
        u_key_start (.clk(vga_clk), .rst(rst_sys), .i_key(key_start), .o_pulse(w_p_start));

    game_state_t r_state,  w_state_nxt;
    move_state_t r_mstate, w_mstate_nxt;
    logic [4:0]  r_num_q, w_num_q_nxt;
    logic [4:0]  r_x, w_x_nxt, r_y, w_y_nxt;
    logic [4:0]  r_tx, w_tx_nxt, r_ty, w_ty_nxt;
    logic [8:0]  r_idx, w_idx_nxt;
    logic [9:0]  r_steps, w_steps_nxt;
    logic        w_move_start;
    logic        w_any_dir;
    logic        w_at_goal;

    assign w_any_dir = w_p_up | w_p_down | w_p_left | w_p_right;
    assign w_at_goal = (r_x == (r_num_q - 5'd2)) && (r_y == (r_num_q - 5'd2));

    always_comb begin
        w_state_nxt  = r_state;
        w_mstate_nxt = r_mstate;
        w_num_q_nxt  = r_num_q;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_tx_nxt     = r_tx;
        w_ty_nxt     = r_ty;
        w_idx_nxt    = r_idx;
        w_steps_nxt  = r_steps;
        w_move_start = 1'b0;
        case (r_state)
            ST_WELCOME: begin
                if (w_p_start && (num >= NUM_MIN) && (num <= NUM_MAX)) begin
                    w_state_nxt  = ST_PLAY;
                    w_mstate_nxt = M_IDLE;
                    w_num_q_nxt  = num;
                    w_x_nxt      = START_POS;
                    w_y_nxt      = START_POS;
                    w_steps_nxt  = 10'd0;
                end
            end
            ST_PLAY: begin
                case (r_mstate)
                    M_IDLE: begin
                        if (w_at_goal) begin
                            w_state_nxt = ST_WIN;
                        end else if (w_any_dir) begin
                            // Priority up > down > left > right; the rest are dropped.
                            w_move_start = 1'b1;
                            w_mstate_nxt = M_CALC;
                            w_tx_nxt     = r_x;
                            w_ty_nxt     = r_y;
                            if (w_p_up)        w_ty_nxt = r_y - 5'd1;
                            else if (w_p_down) w_ty_nxt = r_y + 5'd1;
                            else if (w_p_left) w_tx_nxt = r_x - 5'd1;
                            else               w_tx_nxt = r_x + 5'd1;
                        end
                    end
                    M_CALC: begin
                        // Underflow wraps to 31, so the range test also rejects it.
                        if ((r_tx >= r_num_q) || (r_ty >= r_num_q)) begin
                            w_mstate_nxt = M_IDLE;
                        end else begin
                            w_idx_nxt    = map_index(r_tx, r_ty, r_num_q);
                            w_mstate_nxt = M_CHECK;
                        end
                    end
                    M_CHECK: begin
                        w_mstate_nxt = map[r_idx] ? M_WAIT : M_IDLE;
                    end
                    M_WAIT: begin
                        if (frame_start) begin
                            w_x_nxt      = r_tx;
                            w_y_nxt      = r_ty;
                            w_steps_nxt  = (r_steps == 10'd1023) ? r_steps : r_steps + 10'd1;
                            w_mstate_nxt = M_IDLE;
                        end
                    end
                endcase
            end
            ST_WIN: begin
                if (w_p_start) w_state_nxt = ST_WELCOME;
            end
            default: w_state_nxt = ST_WELCOME;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (rst_sys) begin
            r_state  <= ST_WELCOME;
            r_mstate <= M_IDLE;
            r_num_q  <= NUM_MIN;
            r_x      <= START_POS;
            r_y      <= START_POS;
            r_tx     <= START_POS;
            r_ty     <= START_POS;
            r_idx    <= 9'd0;
            r_steps  <= 10'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mstate <= w_mstate_nxt;
            r_num_q  <= w_num_q_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_tx     <= w_tx_nxt;
            r_ty     <= w_ty_nxt;
            r_idx    <= w_idx_nxt;
            r_steps  <= w_steps_nxt;
        end
    end

    assign state      = r_state;
    assign x_index    = r_x;
    assign y_index    = r_y;
    assign step_count = r_steps;
    assign move_busy  = (r_mstate != M_IDLE) || w_move_start;

endmodule

`default_nettype wire

// File: tb/tb_maze_game_ctrl.sv
// ============================================================================
// Module      : tb_maze_game_ctrl
// Description : Scoreboard bench for maze_game_ctrl with shortened debounce and
//               repeat times; expected commits are queued and matched on commit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_maze_game_ctrl;

    localparam int c_DB  = 4;
    localparam int c_REP = 40;

    logic         clk;
    logic         rst_sys;
    logic [4:0]   keys;          // {start, right, left, down, up}
    logic         frame_start;
    logic [4:0]   num;
    logic [360:0] map_r;
    logic [1:0]   state;
    logic [4:0]   x_index, y_index;
    logic [9:0]   step_count;
    logic         move_busy;

    int n_vec = 0;
    int n_err = 0;

    logic [19:0] sb[$];          // {x, y, steps}
    logic [4:0]  mx, my, numq;
    logic [9:0]  msteps;
    logic [9:0]  prev_steps;

    maze_game_ctrl #(.DEBOUNCE_CYCLES(c_DB), .REPEAT_CYCLES(c_REP)) dut (
        .vga_clk(clk), .rst_sys(rst_sys),
        .key_up(keys[0]), .key_down(keys[1]), .key_left(keys[2]),
        .key_right(keys[3]), .key_start(keys[4]),
        .frame_start(frame_start), .num(num), .map(map_r),
        .state(state), .x_index(x_index), .y_index(y_index),
        .step_count(step_count), .move_busy(move_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Commit monitor: every step increment must match the oldest queued move.
    always @(negedge clk) begin
        if (!rst_sys && (step_count != prev_steps) && (step_count != 10'd0)) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 32'd0, 32'd1);
            end else begin
                check("commit", {x_index, y_index, step_count}, sb.pop_front());
            end
        end
        prev_steps = step_count;
    end

    task automatic road(input int x, input int y);
        map_r[y*7 + x] = 1'b1;
    endtask

    task automatic press(input logic [4:0] mask, output int busy_cnt);
        busy_cnt = 0;
        keys = mask;
        repeat (20) begin @(negedge clk); if (move_busy) busy_cnt++; end
        keys = 5'd0;
        repeat (10) begin @(negedge clk); if (move_busy) busy_cnt++; end
    endtask

    task automatic frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
    endtask

    // Model the move of direction dir; extra keys are pressed alongside it.
    task automatic model_move(input int dir);
        logic [4:0] tx, ty;
        bit acc;
        tx = mx; ty = my;
        case (dir)
            0: ty = my - 5'd1;
            1: ty = my + 5'd1;
            2: tx = mx - 5'd1;
            default: tx = mx + 5'd1;
        endcase
        acc = (tx < numq) && (ty < numq);
        if (acc) acc = map_r[int'(ty) * int'(numq) + int'(tx)];
        if (acc) begin
            msteps = msteps + 10'd1;
            sb.push_back({tx, ty, msteps});
            mx = tx; my = ty;
        end
    endtask

    task automatic do_move(input int dir, input logic [4:0] extra, input int exp_busy, input string tag);
        int bc;
        model_move(dir);
        press(5'(1 << dir) | extra, bc);
        if (exp_busy >= 0) check({tag, "_busy"}, bc, exp_busy);
        frame();
        repeat (3) @(negedge clk);
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_pos"}, {x_index, y_index, step_count}, {mx, my, msteps});
    endtask

    task automatic start_game(input logic [4:0] n);
        int bc;
        num = n;
        press(5'b10000, bc);
        if (n >= 5 && n <= 19) begin
            numq = n; mx = 5'd1; my = 5'd1; msteps = 10'd0;
        end
    endtask

    initial begin
        int bc;
        rst_sys = 1'b1; keys = 5'd0; frame_start = 1'b0; num = 5'd7;
        map_r = '0; mx = 5'd1; my = 5'd1; msteps = 10'd0; numq = 5'd7; prev_steps = 10'd0;
        road(1, 0); road(3, 0);
        for (int x = 1; x <= 5; x++) road(x, 1);
        for (int y = 2; y <= 5; y++) road(5, y);
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_pos", {x_index, y_index}, {5'd1, 5'd1});
        check("rst_steps", step_count, 0);
        check("rst_busy", move_busy, 0);
        rst_sys = 1'b0;

        start_game(5'd3);
        check("num3_state", state, 0);
        start_game(5'd20);
        check("num20_state", state, 0);
        start_game(5'd7);
        check("start_state", state, 1);
        check("start_pos", {x_index, y_index, step_count}, {5'd1, 5'd1, 10'd0});

        // First move: position must hold until a frame_start arrives.
        model_move(3);
        press(5'b01000, bc);
        check("hold_x", x_index, 1);
        check("hold_busy", move_busy, 1);
        frame();
        repeat (3) @(negedge clk);
        check("first_drain", sb.size(), 0);
        check("first_pos", {x_index, y_index, step_count}, {5'd2, 5'd1, 10'd1});

        do_move(2, 5'd0, -1, "left");
        do_move(0, 5'd0, -1, "up_row0");
        do_move(0, 5'd0, 2, "up_wrap");       // from row 0, ty wraps to 31
        do_move(1, 5'd0, -1, "down");
        do_move(1, 5'd0, 3, "down_wall");
        do_move(3, 5'd0, -1, "right_a");
        do_move(3, 5'd0, -1, "right_b");
        do_move(0, 5'b00100, -1, "up_left");  // up and left together: up wins
        do_move(1, 5'd0, -1, "down_back");

        // A second press while a move waits for commit is dropped.
        model_move(3);
        press(5'b01000, bc);
        press(5'b01000, bc);
        check("drop_busy", move_busy, 1);
        frame();
        repeat (3) @(negedge clk);
        frame();
        repeat (3) @(negedge clk);
        check("drop_drain", sb.size(), 0);
        check("drop_pos", {x_index, y_index, step_count}, {5'd4, 5'd1, 10'd9});

        do_move(3, 5'd0, -1, "to_col5");
        do_move(1, 5'd0, -1, "d2");
        do_move(1, 5'd0, -1, "d3");
        do_move(1, 5'd0, -1, "d4");
        model_move(1);
        press(5'b00010, bc);
        frame();
        check("commit_cycle_state", state, 1);
        @(negedge clk);
        check("win_state", state, 2);
        check("win_pos", {x_index, y_index, step_count}, {5'd5, 5'd5, 10'd14});
        press(5'b00001, bc);
        press(5'b00100, bc);
        frame();
        repeat (3) @(negedge clk);
        check("win_frozen", {x_index, y_index, step_count}, {5'd5, 5'd5, 10'd14});
        press(5'b10000, bc);
        check("win_to_welcome", state, 0);

        // Second game: hold right along row 1 for three repeat periods.
        road(6, 1);
        start_game(5'd7);
        check("g2_state", state, 1);
        for (int i = 0; i < 4; i++) model_move(3);
        fork
            begin
                keys = 5'b01000;
                repeat (140) @(negedge clk);
                keys = 5'd0;
                repeat (20) @(negedge clk);
            end
            begin
                repeat (16) begin
                    repeat (8) @(negedge clk);
                    frame();
                end
            end
        join
        repeat (3) @(negedge clk);
        check("rep_drain", sb.size(), 0);
        check("rep_pos", {x_index, y_index, step_count}, {5'd5, 5'd1, 10'd4});

        // Reset while a move waits in M_WAIT; no commit may follow.
        press(5'b00010, bc);
        check("pre_rst_busy", move_busy, 1);
        rst_sys = 1'b1;
        @(negedge clk);
        rst_sys = 1'b0;
        check("mid_rst_state", state, 0);
        check("mid_rst_pos", {x_index, y_index, step_count}, {5'd1, 5'd1, 10'd0});
        check("mid_rst_busy", move_busy, 0);
        frame();
        repeat (3) @(negedge clk);
        check("post_rst_pos", {x_index, y_index, step_count}, {5'd1, 5'd1, 10'd0});
        check("post_rst_state", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
